circle_ctrl: RTL
================

# circle_ctrl

Step scheduler for the rotating-segment animation on the 7-segment display chain. It turns two push-button inputs (run/stop, reverse) and a 2-bit speed select into a one-cycle `step_o` strobe, a direction bit and a lap position. The display driver consumes these in place of a free-running counter overflow: `step_o` feeds its advance input and `dir_o` feeds its direction input.

## Interface
- `BASE_DIV`, 4: step period in clocks at `speed_i`=0; must be ≥1.
- `HOLD_STEPS`, 2: number of step periods the animation pauses before a reversal takes effect; must be ≥1.
- `STEPS_PER_LAP`, 16: number of positions around the circle; must be ≥2.
- `DEB_CYCLES`, 4: debounce length in clocks; used only with `CIRCLE_CTRL_DEBOUNCE_EN`.
- `DIV_W`, 8: divider width; must hold `(BASE_DIV<<3)-1`.
- `POS_W`, 4: position width; equals `$clog2(STEPS_PER_LAP)`.

Ports:
- `clk_i` input, 1: single clock.
- `rst_ni` input, 1: synchronous, active-low reset.
- `btn_run_i` input, 1: asynchronous run/stop button, active high.
- `btn_dir_i` input, 1: asynchronous reverse button, active high.
- `speed_i` input, 2: speed select; step period is `BASE_DIV<<speed_i`.
- `step_o` output, 1: one-cycle advance strobe.
- `dir_o` output, 1: direction; 0 is forward (position increments), 1 is reverse.
- `pos_o` output, POS_W: current position, 0..STEPS_PER_LAP-1.
- `lap_o` output, 1: one-cycle pulse, coincident with the `step_o` that wraps `pos_o`.
- `state_o` output, 2: STOP=00, RUN=01, HOLD=10.

## Operation
- **Button front end.** Each button passes through a 2-flop synchroniser, then an optional debouncer, then a rising-edge detect. The result is `run_ev` or `dir_ev`, a one-cycle event. Holding a button produces exactly one event.
- **Divider.**
  - `div_q` counts from 0 to `period-1`, then returns to 0.
  - `period` is latched from `speed_i` whenever `div_q`==0, so a speed change applies from the next period.
  - `div_q` is forced to 0 in STOP and on every state entry.
  - `tc` = (`div_q`==`period-1`).
- **FSM.** Reset state is STOP.
  - STOP:
    - `run_ev` → RUN.
    - `dir_ev` toggles `dir_o` and the state stays STOP.
  - RUN:
    - `tc` asserts `step_o`.
    - `run_ev` → STOP.
    - `dir_ev` → HOLD and clears `hold_cnt`.
  - HOLD:
    - `step_o` stays 0.
    - `hold_cnt` increments on each `tc`.
    - On the `tc` where `hold_cnt`==`HOLD_STEPS-1`: toggle `dir_o` and go to RUN.
    - `run_ev` → STOP with `dir_o` toggled; the pending reversal is committed.
    - `dir_ev` → RUN with `dir_o` unchanged; the reversal is cancelled.
- **Simultaneous events.** `run_ev` and `dir_ev` in the same cycle:
  - STOP → RUN, with `dir_o` toggled.
  - RUN → STOP, with `dir_o` toggled.
  - HOLD → STOP, with `dir_o` unchanged.
- **Position.**
  - On `step_o` with `dir_o`=0: `pos_o`+1, wrapping `STEPS_PER_LAP-1`→0 with `lap_o`=1.
  - On `step_o` with `dir_o`=1: `pos_o`-1, wrapping 0→`STEPS_PER_LAP-1` with `lap_o`=1.
  - Arithmetic is modulo `STEPS_PER_LAP`, not 2^POS_W.

## Timing
- Reset, sampled at a clock edge with `rst_ni`=0: all outputs 0, `state_o`=STOP, and all internal registers 0, including synchronisers, debouncers, `div_q` and `hold_cnt`. Reset asserted mid-RUN or mid-HOLD takes effect at that edge, and no pending reversal survives it.
- Button latency with the debouncer off: the first edge that samples the button high is edge 0; `state_o` or `dir_o` changes at edge 3.
- The debouncer adds `DEB_CYCLES` edges to that latency.
- `step_o`, `lap_o` and the `pos_o` update are registered. `step_o` and `lap_o` are high for the cycle after the `tc` edge, and `pos_o` holds its new value from that same edge.
- First step after entering RUN: `period` cycles after entry.
- Reversal from RUN: `dir_o` flips `HOLD_STEPS*period` cycles after HOLD entry. The first step in the new direction follows `period` cycles later.

## Configuration
- `CIRCLE_CTRL_DEBOUNCE_EN` defined: each synchronised button level must stay stable for `DEB_CYCLES` consecutive cycles before the debounced level changes. Pulses shorter than that are ignored.
- Not defined: the debouncer is absent and the edge detect acts on the synchroniser output directly. `DEB_CYCLES` is unused.

## Test plan
All scenarios use the defaults and debouncer off unless stated.
- Reset, then a 1-cycle press on `btn_run_i` → `state_o`=01 at edge 3. `step_o` every 4 cycles; `pos_o` 0,1,…,15,0; `lap_o` only on the 15→0 step.
- In RUN set `speed_i`=2 → the period becomes 16 cycles starting from the next `div_q`==0. Return to 0 → the period reverts to 4 cycles.
- Press `btn_dir_i` in RUN at `pos_o`=1 → `state_o`=10 and no steps for 8 cycles. Then `dir_o`=1, `state_o`=01, and `pos_o` runs 0,15 with `lap_o` on the 0→15 step.
- Press `btn_dir_i`, then press `btn_run_i` during HOLD → `state_o`=00 with `dir_o`=1. Repeat with both buttons pressed in the same cycle during HOLD → `state_o`=00 with `dir_o`=0.
- Assert `rst_ni`=0 for one cycle mid-HOLD → every output 0 at that edge. After release, no step until a new run press.
- With `CIRCLE_CTRL_DEBOUNCE_EN`: a 2-cycle `btn_run_i` glitch → no state change. A 6-cycle press → `state_o`=01 at edge 7.

Source files
------------

// File: rtl/circle_ctrl.sv
// circle_ctrl: step scheduler for the rotating-segment animation.
//
// Turns a run/stop button, a reverse button and a 2-bit speed select into a
// one-cycle advance strobe, a direction bit and a lap position for the
// 7-segment display driver.
//
// Build option: define CIRCLE_CTRL_DEBOUNCE_EN to insert a DEB_CYCLES-long
// debouncer between each button synchroniser and its edge detector. Without
// it the edge detector works straight off the synchroniser output.
//
// Reset is synchronous and active low; every register, including the
// synchronisers, debouncers, divider and hold counter, clears at that edge.

module circle_ctrl #(
    parameter int BASE_DIV      = 4,   // step period in clocks at speed 0
    parameter int HOLD_STEPS    = 2,   // step periods paused before a reversal
    parameter int STEPS_PER_LAP = 16,  // positions around the circle
    parameter int DEB_CYCLES    = 4,   // debounce length (debouncer builds only)
    parameter int DIV_W         = 8,   // must hold (BASE_DIV << 3) - 1
    parameter int POS_W         = 4    // $clog2(STEPS_PER_LAP)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             btn_run_i,
    input  logic             btn_dir_i,
    input  logic [1:0]       speed_i,
    output logic             step_o,
    output logic             dir_o,
    output logic [POS_W-1:0] pos_o,
    output logic             lap_o,
    output logic [1:0]       state_o
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------
    if (BASE_DIV < 1) begin : g_chk_base_div
        $error("circle_ctrl: BASE_DIV must be >= 1");
    end
    if (HOLD_STEPS < 1) begin : g_chk_hold_steps
        $error("circle_ctrl: HOLD_STEPS must be >= 1");
    end
    if (STEPS_PER_LAP < 2) begin : g_chk_steps_per_lap
        $error("circle_ctrl: STEPS_PER_LAP must be >= 2");
    end
    if (DEB_CYCLES < 1) begin : g_chk_deb_cycles
        $error("circle_ctrl: DEB_CYCLES must be >= 1");
    end
    if (((BASE_DIV << 3) - 1) >= (1 << DIV_W)) begin : g_chk_div_w
        $error("circle_ctrl: DIV_W too narrow for the slowest period");
    end
    if (POS_W != $clog2(STEPS_PER_LAP)) begin : g_chk_pos_w
        $error("circle_ctrl: POS_W must equal $clog2(STEPS_PER_LAP)");
    end

    typedef enum logic [1:0] {
        ST_STOP = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    localparam int HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

    // Bit 0 carries the run/stop button, bit 1 the reverse button.
    localparam int BTN_RUN = 0;
    localparam int BTN_DIR = 1;

    // ------------------------------------------------------------------
    // Button front end: synchroniser -> optional debouncer -> edge detect
    // ------------------------------------------------------------------
    logic [1:0] btn_raw;
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] level;
    logic [1:0] level_q;
    logic [1:0] ev_q;
    logic       run_ev;
    logic       dir_ev;

    assign btn_raw = {btn_dir_i, btn_run_i};

    // Two-flop synchroniser for both asynchronous buttons.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            // NOTE: non-blocking assignments let sync2_q take the old sync1_q,
            // giving two real flop stages; blocking would collapse them into one.
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

`ifdef CIRCLE_CTRL_DEBOUNCE_EN
    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [1:0]       deb_q;
    logic [DEB_W-1:0] deb_cnt_q [2];

    // Debouncer: the level follows the synchroniser only once it has
    // disagreed with the current level for DEB_CYCLES consecutive cycles.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            deb_q <= '0;
            // NOTE: this two-entry counter array is ordinary flops rather than
            // a RAM, so it is cleared by reset like any other register.
            for (int b = 0; b < 2; b++) begin
                deb_cnt_q[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (sync2_q[b] == deb_q[b]) begin
                    deb_cnt_q[b] <= '0;
                end else if (deb_cnt_q[b] == DEB_W'(DEB_CYCLES - 1)) begin
                    deb_q[b]     <= sync2_q[b];
                    deb_cnt_q[b] <= '0;
                end else begin
                    deb_cnt_q[b] <= deb_cnt_q[b] + DEB_W'(1);
                end
            end
        end
    end

    assign level = deb_q;
`else
    assign level = sync2_q;
`endif

    // Rising-edge detect; the event is registered so it is a clean strobe.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            level_q <= '0;
            ev_q    <= '0;
        end else begin
            level_q <= level;
            ev_q    <= level & ~level_q;
        end
    end

    assign run_ev = ev_q[BTN_RUN];
    assign dir_ev = ev_q[BTN_DIR];

    // ------------------------------------------------------------------
    // Divider and position helpers
    // ------------------------------------------------------------------
    state_t           state_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] period_q;
    logic [DIV_W-1:0] period_cur;
    logic [DIV_W-1:0] div_inc;
    logic             tc;
    logic [HOLD_W-1:0] hold_cnt;
    logic [POS_W-1:0] pos_next;
    logic             lap_next;

    // Period in force for this cycle: a fresh period samples speed_i at
    // div_q==0, otherwise the value latched at the start of the period holds.
    always_comb begin
        // NOTE: every signal gets a default before any condition, so no
        // path leaves it unassigned and no latch is inferred.
        period_cur = period_q;
        if (div_q == '0) begin
            period_cur = DIV_W'(BASE_DIV) << speed_i;
        end
        tc      = (state_q != ST_STOP) && (div_q == period_cur - DIV_W'(1));
        div_inc = tc ? '0 : div_q + DIV_W'(1);
    end

    // Next position and lap flag for a step in the current direction,
    // wrapping modulo STEPS_PER_LAP rather than 2**POS_W.
    always_comb begin
        pos_next = pos_o;
        lap_next = 1'b0;
        if (!dir_o) begin
            if (pos_o == POS_W'(STEPS_PER_LAP - 1)) begin
                pos_next = '0;
                lap_next = 1'b1;
            end else begin
                pos_next = pos_o + POS_W'(1);
            end
        end else begin
            if (pos_o == '0) begin
                pos_next = POS_W'(STEPS_PER_LAP - 1);
                lap_next = 1'b1;
            end else begin
                pos_next = pos_o - POS_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------

    // STOP/RUN/HOLD sequencing, divider, hold counter, direction and position.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= ST_STOP;
            div_q    <= '0;
            period_q <= '0;
            hold_cnt <= '0;
            step_o   <= 1'b0;
            lap_o    <= 1'b0;
            dir_o    <= 1'b0;
            pos_o    <= '0;
        end else begin
            step_o <= 1'b0;
            lap_o  <= 1'b0;
            if (div_q == '0) begin
                period_q <= period_cur;
            end

            unique case (state_q)
                ST_STOP: begin
                    div_q <= '0;
                    if (dir_ev) begin
                        dir_o <= ~dir_o;
                    end
                    if (run_ev) begin
                        state_q <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    div_q <= div_inc;
                    if (tc) begin
                        step_o <= 1'b1;
                        lap_o  <= lap_next;
                        pos_o  <= pos_next;
                    end
                    if (run_ev) begin
                        // A simultaneous reverse press is applied on the way out.
                        state_q <= ST_STOP;
                        div_q   <= '0;
                        if (dir_ev) begin
                            dir_o <= ~dir_o;
                        end
                    end else if (dir_ev) begin
                        state_q  <= ST_HOLD;
                        div_q    <= '0;
                        hold_cnt <= '0;
                    end
                end

                ST_HOLD: begin
                    div_q <= div_inc;
                    if (run_ev) begin
                        // Stopping commits the pending reversal unless the
                        // reverse button was pressed again in the same cycle.
                        state_q <= ST_STOP;
                        div_q   <= '0;
                        if (!dir_ev) begin
                            dir_o <= ~dir_o;
                        end
                    end else if (dir_ev) begin
                        // Second reverse press cancels the reversal.
                        state_q <= ST_RUN;
                        div_q   <= '0;
                    end else if (tc) begin
                        if (hold_cnt == HOLD_W'(HOLD_STEPS - 1)) begin
                            dir_o   <= ~dir_o;
                            state_q <= ST_RUN;
                            div_q   <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                end

                default: begin
                    state_q <= ST_STOP;
                    div_q   <= '0;
                end
            endcase
        end
    end

    assign state_o = state_q;

endmodule
